sata_dma_stream_buffer: RTL

- Single-clock, parametrised show-ahead stream FIFO for the SATA DMA datapath, placed between DMA engine stages that share one clock domain.
- Adds what the dual-clock resync buffer lacks: an exact fill level, programmable almost-full/almost-empty flags, a synchronous flush, and a bounded-latency guarantee.
- Uses the same valid/ready stream handshake on both sides, so it drops into any existing DMA stream path.

---
 rtl/sata_dma_stream_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sata_dma_stream_buffer.sv
// Single-clock show-ahead stream FIFO for the SATA DMA datapath: exact fill level,
// almost-full/almost-empty decodes, synchronous flush and one-cycle fall-through.
module sata_dma_stream_buffer #(
    parameter int DWIDTH  = 32,
    parameter int DEPTH   = 16,
    parameter int AFULL   = 12,
    parameter int AEMPTY  = 4,
    parameter     RAMTYPE = "AUTO"
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [DWIDTH-1:0]        wr_dat,
    input  logic                     wr_val,
    output logic                     wr_rdy,
    output logic [DWIDTH-1:0]        rd_dat,
    output logic                     rd_val,
    input  logic                     rd_rdy,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic                     almost_full,
    output logic                     almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_AFULL  = (AW+1)'(AFULL);
    localparam logic [AW:0]   LVL_AEMPTY = (AW+1)'(AEMPTY);
    localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic              r_init;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_usedw;
    logic [DWIDTH-1:0] r_ram_q;
    logic [DWIDTH-1:0] r_byp_dat;
    logic              r_byp_sel;

    logic              w_wr;
    logic              w_rd;
    logic              w_wr_eff;
    logic              w_byp;
    logic [AW-1:0]     w_rd_addr_next;
    logic [AW:0]       w_usedw;

    // Status is forced to its idle values while reset is asserted.
    assign w_usedw      = reset ? '0 : r_usedw;
    assign wr_rdy       = ~reset & ~r_init & (r_usedw < LVL_FULL);
    assign rd_val       = ~reset & (r_usedw != '0);
    assign usedw        = w_usedw;
    assign almost_full  = (w_usedw >= LVL_AFULL);
    assign almost_empty = (w_usedw <= LVL_AEMPTY);

    assign w_wr     = wr_val & wr_rdy;
    assign w_rd     = rd_val & rd_rdy;
    assign w_wr_eff = w_wr & ~flush;

    // The RAM is read one edge ahead at the address that will be the head next cycle.
    always_comb begin
        w_rd_addr_next = w_rd ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
        if (reset || flush) begin
            w_rd_addr_next = '0;
        end
    end

    // A word written into the slot that becomes the head cannot come out of the RAM yet.
    assign w_byp  = w_wr_eff & (r_wr_ptr == w_rd_addr_next);
    assign rd_dat = r_byp_sel ? r_byp_dat : r_ram_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_init   <= 1'b1;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
        end else begin
            r_init <= 1'b0;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_usedw  <= '0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_rd) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                case ({w_wr, w_rd})
                    2'b10:   r_usedw <= r_usedw + LVL_ONE;
                    2'b01:   r_usedw <= r_usedw - LVL_ONE;
                    default: r_usedw <= r_usedw;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        r_byp_sel <= w_byp;
        r_byp_dat <= wr_dat;
    end

    generate
        if (RAMTYPE == "AUTO") begin : g_ram_auto
            logic [DWIDTH-1:0] r_mem [0:DEPTH-1];

            always_ff @(posedge clk) begin
                if (w_wr_eff) begin
                    r_mem[r_wr_ptr] <= wr_dat;
                end
                r_ram_q <= r_mem[w_rd_addr_next];
            end
        end else begin : g_ram_hint
            (* ramstyle = RAMTYPE *) logic [DWIDTH-1:0] r_mem [0:DEPTH-1];

            always_ff @(posedge clk) begin
                if (w_wr_eff) begin
                    r_mem[r_wr_ptr] <= wr_dat;
                end
                r_ram_q <= r_mem[w_rd_addr_next];
            end
        end
    endgenerate

`ifndef SYNTHESIS
    a_usedw_range: assert property (@(posedge clk) disable iff (reset)
        r_usedw <= LVL_FULL);
    a_no_write_full: assert property (@(posedge clk) disable iff (reset)
        !(wr_val && wr_rdy && (r_usedw == LVL_FULL)));
    a_no_read_empty: assert property (@(posedge clk) disable iff (reset)
        !(rd_val && rd_rdy && (r_usedw == '0)));
`endif

endmodule
